mdu_ex: RTL and testbench
=========================

# mdu_ex

Multiply/divide unit in the Ex stage, directly downstream of the decode stage that supplies forwarded rs/rt operands and the decoded instruction. Executes mult/multu/div/divu with fixed multi-cycle latency, services mthi/mtlo writes, and holds the HI/LO architectural registers read by mfhi/mflo. Exposes `busy` so the hazard unit can stall any multiply/divide-class instruction sitting in decode.

## Interface
- `MULT_CYCLES`, 5, cycles from accept edge to HI/LO update for mult/multu (≥1)
- `DIV_CYCLES`, 10, cycles from accept edge to HI/LO update for div/divu (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `mdStart`  in  1  Ex-stage instruction is a valid, non-flushed MD op this cycle
- `mdOp`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved (treated as none)
- `srcA`  in  32  forwarded rs value
- `srcB`  in  32  forwarded rt value
- `busy`  out  1  registered; high while a mult/div is in flight
- `done`  out  1  registered; one-cycle pulse in the first cycle results are visible
- `hi`  out  32  registered HI
- `lo`  out  32  registered LO

## Operation
- FSM states: IDLE, MUL, DIV; down-counter `cnt` (4+ bits, width from max of parameters).
- Accept: rising edge with `mdStart`=1, state IDLE. mult/multu → MUL, `cnt`=MULT_CYCLES; div/divu → DIV, `cnt`=DIV_CYCLES. srcA/srcB and signedness latched at accept; later operand changes have no effect.
- In MUL/DIV: `cnt` decrements each edge; on the edge where `cnt`=1, HI/LO written, state → IDLE, `busy`→0, `done`→1.
- mult: {HI,LO} = $signed(A)×$signed(B), 64 bits. multu: unsigned 64-bit product.
- div: LO = quotient truncated toward zero, HI = remainder with sign of dividend. divu: unsigned quotient/remainder.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor zero (div or divu): operation runs full latency, `done` pulses, HI and LO keep prior values.
- mthi/mtlo: in IDLE, HI (resp. LO) ← srcA at the edge; no busy, no done.
- `mdStart` while busy: ignored entirely (no state, counter, or HI/LO change). Hazard unit guarantees this does not occur in legal flow.
- op none/reserved with `mdStart`=1: no effect.

## Timing
- Reset (async assert): state IDLE, `cnt`=0, `busy`=0, `done`=0, `hi`=0, `lo`=0. Reset mid-operation aborts it; no partial write.
- Accept at edge t: `busy`=1 in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES); HI/LO new and `done`=1 in cycle t+N+1 only; `busy`=0 from t+N+1.
- Back-to-back: new accept legal at edge t+N+1 (same edge `done` drops unless another completion).
- mthi/mtlo at edge t: `hi`/`lo` updated in cycle t+1.
- Hazard stall condition for a decode-stage MD instruction is `busy` | (`mdStart` with mult/div op); this block provides only `busy`.

## Structure
- Shared package `mdu_pkg`: op encoding constants (MD_NONE … MD_MTLO), state encoding, default cycle counts.
- Sub-module `mdu_core`: combinational 64-bit result {hiNext, loNext} from latched operands and op, including divide-by-zero and overflow rules; FSM/counter/registers stay in `mdu_ex`.

## Test plan
- mult srcA=0xFFFFFFFE (−2), srcB=3 → busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- multu srcA=0xFFFFFFFF, srcB=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div srcA=−7 (0xFFFFFFF9), srcB=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 after prior hi=0x11, lo=0x22 → values unchanged, done still pulses.
- mthi srcA=0xDEADBEEF then mtlo srcA=0x12345678 on consecutive edges → hi/lo updated one cycle each, busy never asserts; mthi during busy → ignored.
- Start div, change srcA/srcB every cycle and assert mdStart with mult mid-flight → result equals latched operands, second op ignored, busy stays exactly 10 cycles.
- Start mult, deassert reset at cycle 3 of 5 → busy/done/hi/lo = 0 immediately (async), no later write; new mult after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the Ex-stage multiply/divide unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: op encodings carried on mdOp, FSM state encoding, default cycle counts.
package mdu_pkg;

  // mdOp encodings; 7 is reserved and behaves like MD_NONE
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Bundle between decode/Ex and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; the hazard unit stalls on busy.
// Ports: mdStart/mdOp/srcA/srcB toward the unit; busy/done/hi/lo back out.
interface mdu_if;
  logic        mdStart;
  logic [2:0]  mdOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output mdStart, mdOp, srcA, srcB,
    input  busy, done, hi, lo
  );

  modport slave (
    input  mdStart, mdOp, srcA, srcB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_core.sv
// Combinational HI/LO result for a latched mult/multu/div/divu operation.
// Latency: combinational; sampled by mdu_ex on its completion edge.
// Backpressure: none.
// Ports: op/a/b latched operands, hi_prev/lo_prev current HI/LO, hi_next/lo_next result.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_prev,
  input  logic [31:0] lo_prev,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        b_zero;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes. 0x80000000 keeps its own bit pattern
    // as magnitude, so the -2^31 / -1 case wraps back to 0x80000000 with
    // remainder 0 without needing a special case.
    a_neg  = (op == MD_DIV) & a[31];
    b_neg  = (op == MD_DIV) & b[31];
    a_mag  = a_neg ? (~a + 32'd1) : a;
    b_mag  = b_neg ? (~b + 32'd1) : b;
    b_zero = (b == 32'd0);
    b_div  = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    hi_next = hi_prev;
    lo_next = lo_prev;
    case (op)
      MD_MULT:  {hi_next, lo_next} = prod_s;
      MD_MULTU: {hi_next, lo_next} = prod_u;
      MD_DIV, MD_DIVU: begin
        // divide by zero leaves HI/LO untouched
        if (!b_zero) begin
          hi_next = rem;
          lo_next = quo;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ex.sv
// Ex-stage multiply/divide unit: fixed-latency mult/div, mthi/mtlo, HI/LO state.
// Latency: MULT_CYCLES / DIV_CYCLES edges from accept to HI/LO update; mthi/mtlo one edge.
// Backpressure: busy high while in flight; any mdStart seen while busy is dropped.
// Ports: clk, reset (async active-low), md (mdu_if slave).
module mdu_ex
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave md
);

  localparam int MAX_CYC   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W_RAW = $clog2(MAX_CYC + 1);
  localparam int CNT_W     = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      core_hi;
  logic [31:0]      core_lo;

  mdu_core u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi_prev (hi_q),
    .lo_prev (lo_q),
    .hi_next (core_hi),
    .lo_next (core_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      ST_IDLE: begin
        if (md.mdStart) begin
          case (md.mdOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              // operands and op (hence signedness) frozen here
              op_d   = md.mdOp;
              a_d    = md.srcA;
              b_d    = md.srcB;
              busy_d = 1'b1;
              if ((md.mdOp == MD_MULT) || (md.mdOp == MD_MULTU)) begin
                state_d = ST_MUL;
                cnt_d   = CNT_W'(MULT_CYCLES);
              end else begin
                state_d = ST_DIV;
                cnt_d   = CNT_W'(DIV_CYCLES);
              end
            end
            MD_MTHI: hi_d = md.srcA;
            MD_MTLO: lo_d = md.srcA;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = core_hi;
          lo_d    = core_lo;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ex.sv
// Directed bench for mdu_ex: hand-computed HI/LO vectors, busy/done timing,
// ignored starts while busy, divide-by-zero hold, and asynchronous reset abort.
module tb_mdu_ex;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if u_if ();

  mdu_ex #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents an op for exactly one rising edge, returns 1ns after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.mdStart = 1'b1;
    u_if.mdOp    = op;
    u_if.srcA    = a;
    u_if.srcB    = b;
    @(posedge clk);
    #1;
    u_if.mdStart = 1'b0;
    u_if.mdOp    = MD_NONE;
  endtask

  // Checks n busy cycles (HI/LO holding previous values), then the done cycle.
  // Optionally injects one op during busy cycle inj_cyc and/or scrambles operands.
  task automatic run_check(input string tag, input int n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int inj_cyc, input logic [2:0] inj_op, input bit scramble);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {30'd0, u_if.busy, u_if.done}, 32'd2);
      chk({tag, "_hold_hi"}, u_if.hi, m_hi);
      chk({tag, "_hold_lo"}, u_if.lo, m_lo);
      if (scramble) begin
        u_if.srcA = $urandom;
        u_if.srcB = $urandom;
      end
      u_if.mdStart = (i == inj_cyc);
      u_if.mdOp    = inj_op;
    end
    @(negedge clk);
    chk({tag, "_done"}, {30'd0, u_if.busy, u_if.done}, 32'd1);
    chk({tag, "_hi"}, u_if.hi, exp_hi);
    chk({tag, "_lo"}, u_if.lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  // mthi then mtlo on consecutive edges; starts and ends at a falling edge.
  task automatic mt_pair(input string tag, input logic [31:0] h, input logic [31:0] l);
    u_if.mdStart = 1'b1;
    u_if.mdOp    = MD_MTHI;
    u_if.srcA    = h;
    @(posedge clk);
    #1;
    u_if.mdOp = MD_MTLO;
    u_if.srcA = l;
    @(negedge clk);
    chk({tag, "_hi_flags"}, {30'd0, u_if.busy, u_if.done}, 32'd0);
    chk({tag, "_hi"}, u_if.hi, h);
    chk({tag, "_lo_old"}, u_if.lo, m_lo);
    @(posedge clk);
    #1;
    u_if.mdStart = 1'b0;
    u_if.mdOp    = MD_NONE;
    @(negedge clk);
    chk({tag, "_lo_flags"}, {30'd0, u_if.busy, u_if.done}, 32'd0);
    chk({tag, "_hi_keep"}, u_if.hi, h);
    chk({tag, "_lo"}, u_if.lo, l);
    m_hi = h;
    m_lo = l;
  endtask

  initial begin
    reset        = 1'b0;
    u_if.mdStart = 1'b0;
    u_if.mdOp    = MD_NONE;
    u_if.srcA    = 32'd0;
    u_if.srcB    = 32'd0;
    #12;
    chk("rst_flags", {30'd0, u_if.busy, u_if.done}, 32'd0);
    chk("rst_hi", u_if.hi, 32'd0);
    chk("rst_lo", u_if.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    run_check("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, MD_NONE, 1'b0);
    // accepted on the same edge that ends done
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("multu", 5, 32'hFFFF_FFFE, 32'h0000_0001, -1, MD_NONE, 1'b0);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_check("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, MD_NONE, 1'b0);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div_ovf", 10, 32'h0000_0000, 32'h8000_0000, -1, MD_NONE, 1'b0);

    mt_pair("mt1", 32'hDEAD_BEEF, 32'h1234_5678);
    mt_pair("mt2", 32'h0000_0011, 32'h0000_0022);

    issue(MD_DIVU, 32'd7, 32'd0);
    run_check("divu0", 10, 32'h0000_0011, 32'h0000_0022, -1, MD_NONE, 1'b0);
    @(negedge clk);
    chk("done_drop", {30'd0, u_if.busy, u_if.done}, 32'd0);

    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    run_check("div_negb", 10, 32'h0000_0001, 32'hFFFF_FFFD, -1, MD_NONE, 1'b0);
    issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
    run_check("divu", 10, 32'h0000_0001, 32'h7FFF_FFFC, -1, MD_NONE, 1'b0);

    // 100 / -7: operands scrambled every cycle, mult start injected mid-flight
    issue(MD_DIV, 32'd100, 32'hFFFF_FFF9);
    run_check("div_scr", 10, 32'h0000_0002, 32'hFFFF_FFF2, 3, MD_MULT, 1'b1);
    @(negedge clk);
    chk("post_scr", {30'd0, u_if.busy, u_if.done}, 32'd0);

    issue(MD_MULT, 32'd5, 32'd5);
    run_check("mul_mthi", 5, 32'h0000_0000, 32'h0000_0019, 2, MD_MTHI, 1'b0);
    issue(MD_DIVU, 32'd9, 32'd0);
    run_check("div0_mtlo", 10, 32'h0000_0000, 32'h0000_0019, 4, MD_MTLO, 1'b0);

    // Reset during cycle 3 of a mult aborts it with no later write
    issue(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    chk("abort_c1", {30'd0, u_if.busy, u_if.done}, 32'd2);
    @(negedge clk);
    chk("abort_c2", {30'd0, u_if.busy, u_if.done}, 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_flags", {30'd0, u_if.busy, u_if.done}, 32'd0);
    chk("abort_hi", u_if.hi, 32'd0);
    chk("abort_lo", u_if.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("abort_quiet", {30'd0, u_if.busy, u_if.done}, 32'd0);
      chk("abort_lo_keep", u_if.lo, 32'd0);
    end
    issue(MD_MULT, 32'd6, 32'd7);
    run_check("mult_post", 5, 32'h0000_0000, 32'h0000_002A, -1, MD_NONE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
